// File: rtl/lw_hazard_stall_controller_if.sv
// Signal bundle between the MIPS32 ID/EX/MEM pipeline registers and the load-use/dmem stall controller.
// dmem_ready is sampled each cycle a load sits in MEM: high means read data is valid and the load completes; low means hold.
interface lw_hazard_stall_controller_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic                  id_lw;
  logic [REG_ADDR_W-1:0] id_dest;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  dmem_ready;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  idex_write;
  logic                  idex_bubble;
  logic                  exmem_write;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_count;
  logic [1:0]            dbg_state;

  modport master (
    output id_valid, id_lw, id_dest, id_rs, id_rt, id_uses_rs, id_uses_rt, dmem_ready,
    input  pc_write, ifid_write, idex_write, idex_bubble, exmem_write, mem_timeout,
           stall_count, dbg_state
  );

  modport slave (
    input  id_valid, id_lw, id_dest, id_rs, id_rt, id_uses_rs, id_uses_rt, dmem_ready,
    output pc_write, ifid_write, idex_write, idex_bubble, exmem_write, mem_timeout,
           stall_count, dbg_state
  );
endinterface

// File: rtl/lw_hazard_stall_controller.sv
// Load-use hazard detection and variable-latency dmem freeze for a 5-stage MIPS32 pipeline.
// Tracks lw in EX and MEM, inserts ID/EX bubbles, and freezes everything while a load waits on dmem.
module lw_hazard_stall_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int FORWARDING   = 1,
  parameter int MAX_MEM_WAIT = 15,
  parameter int CNT_W        = 16
) (
  input logic                      clock,
  input logic                      reset_n,
  lw_hazard_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  localparam bit           L_USE_MEM_HZ = (FORWARDING == 0);
  localparam logic [8:0]   L_MAX_WAIT   = 9'(MAX_MEM_WAIT);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ex_lw;
  logic [REG_ADDR_W-1:0] r_ex_dest;
  logic                  r_mem_lw;
  logic [REG_ADDR_W-1:0] r_mem_dest;
  logic [7:0]            r_wait_cnt;
  logic [7:0]            w_wait_cnt_nxt;
  logic [8:0]            w_cnt_inc;
  logic [CNT_W-1:0]      r_stall_count;
  logic                  w_hz_ex;
  logic                  w_hz_mem;
  logic                  w_hazard;
  logic                  w_wait;
  logic                  w_err;
  logic                  w_freeze;
  logic                  w_bubble;

  assign w_hz_ex  = bus.id_valid & r_ex_lw & (r_ex_dest != '0) &
                    ((bus.id_uses_rs & (bus.id_rs == r_ex_dest)) |
                     (bus.id_uses_rt & (bus.id_rt == r_ex_dest)));
  assign w_hz_mem = bus.id_valid & r_mem_lw & (r_mem_dest != '0) &
                    ((bus.id_uses_rs & (bus.id_rs == r_mem_dest)) |
                     (bus.id_uses_rt & (bus.id_rt == r_mem_dest)));
  assign w_hazard = w_hz_ex | (L_USE_MEM_HZ & w_hz_mem);
  assign w_wait   = r_mem_lw & ~bus.dmem_ready;
  assign w_err    = (r_state == S_ERROR);
  // A pending dmem wait outranks the hazard; the bubble follows once the freeze releases.
  assign w_freeze = ~w_err & w_wait;
  assign w_bubble = ~w_err & ~w_wait & w_hazard;
  assign w_cnt_inc = {1'b0, r_wait_cnt} + 9'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_RUN, S_MEM_WAIT: begin
        if (w_wait) begin
          w_wait_cnt_nxt = w_cnt_inc[7:0];
          w_state_nxt    = (w_cnt_inc >= L_MAX_WAIT) ? S_ERROR : S_MEM_WAIT;
        end else begin
          w_wait_cnt_nxt = '0;
          w_state_nxt    = S_RUN;
        end
      end
      default: w_state_nxt = S_ERROR;
    endcase
  end

  always_comb begin
    bus.pc_write    = 1'b0;
    bus.ifid_write  = 1'b0;
    bus.idex_write  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.exmem_write = 1'b0;
    bus.mem_timeout = 1'b0;
    if (!reset_n) begin
      bus.mem_timeout = 1'b0;
    end else if (w_err) begin
      bus.mem_timeout = 1'b1;
    end else if (w_wait) begin
      bus.pc_write = 1'b0;
    end else if (w_hazard) begin
      bus.idex_write  = 1'b1;
      bus.idex_bubble = 1'b1;
      bus.exmem_write = 1'b1;
    end else begin
      bus.pc_write    = 1'b1;
      bus.ifid_write  = 1'b1;
      bus.idex_write  = 1'b1;
      bus.exmem_write = 1'b1;
    end
  end

  // Slots mirror the lw-ness of whatever sits in the EX and MEM pipeline registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_lw    <= 1'b0;
      r_ex_dest  <= '0;
      r_mem_lw   <= 1'b0;
      r_mem_dest <= '0;
    end else if (!w_freeze && !w_err) begin
      r_mem_lw   <= r_ex_lw;
      r_mem_dest <= r_ex_dest;
      if (w_bubble) begin
        r_ex_lw   <= 1'b0;
        r_ex_dest <= '0;
      end else begin
        r_ex_lw   <= bus.id_valid & bus.id_lw;
        r_ex_dest <= bus.id_dest;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= '0;
    end else if ((w_freeze || w_bubble) && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign bus.stall_count = r_stall_count;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_lw_hazard_stall_controller.sv
// Bench for lw_hazard_stall_controller: one instance with forwarding, one without, fed identical stimulus.
// A cycle-level reference model predicts control outputs and stall count for each instance.
module tb_lw_hazard_stall_controller;
  localparam int RW   = 5;
  localparam int CW   = 16;
  localparam int MAXW = 15;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic          t_valid, t_lw, t_urs, t_urt, t_rdy;
  logic [RW-1:0] t_dest, t_rs, t_rt;

  lw_hazard_stall_controller_if #(.REG_ADDR_W(RW), .CNT_W(CW)) if0 ();
  lw_hazard_stall_controller_if #(.REG_ADDR_W(RW), .CNT_W(CW)) if1 ();

  assign if0.id_valid = t_valid;   assign if1.id_valid = t_valid;
  assign if0.id_lw = t_lw;         assign if1.id_lw = t_lw;
  assign if0.id_dest = t_dest;     assign if1.id_dest = t_dest;
  assign if0.id_rs = t_rs;         assign if1.id_rs = t_rs;
  assign if0.id_rt = t_rt;         assign if1.id_rt = t_rt;
  assign if0.id_uses_rs = t_urs;   assign if1.id_uses_rs = t_urs;
  assign if0.id_uses_rt = t_urt;   assign if1.id_uses_rt = t_urt;
  assign if0.dmem_ready = t_rdy;   assign if1.dmem_ready = t_rdy;

  lw_hazard_stall_controller #(.REG_ADDR_W(RW), .FORWARDING(1), .MAX_MEM_WAIT(MAXW), .CNT_W(CW))
    u_fwd (.clock(clock), .reset_n(reset_n), .bus(if0.slave));
  lw_hazard_stall_controller #(.REG_ADDR_W(RW), .FORWARDING(0), .MAX_MEM_WAIT(MAXW), .CNT_W(CW))
    u_nofwd (.clock(clock), .reset_n(reset_n), .bus(if1.slave));

  // Output vector order: {pc_write, ifid_write, idex_write, idex_bubble, exmem_write, mem_timeout}
  logic [5:0]    obs_vec [2];
  logic [CW-1:0] obs_cnt [2];
  assign obs_vec[0] = {if0.pc_write, if0.ifid_write, if0.idex_write, if0.idex_bubble, if0.exmem_write, if0.mem_timeout};
  assign obs_vec[1] = {if1.pc_write, if1.ifid_write, if1.idex_write, if1.idex_bubble, if1.exmem_write, if1.mem_timeout};
  assign obs_cnt[0] = if0.stall_count;
  assign obs_cnt[1] = if1.stall_count;

  int checks = 0;
  int errors = 0;
  int bub_seen [2];
  int frz_seen [2];

  // Reference model: what each pipeline stage holds, how long the current load has waited.
  bit            m_ex_lw   [2];
  logic [RW-1:0] m_ex_dest [2];
  bit            m_mem_lw  [2];
  logic [RW-1:0] m_mem_dest[2];
  int            m_waits   [2];
  bit            m_err     [2];
  int            m_cnt     [2];

  function automatic bit mdl_hz(int d);
    bit hx, hm;
    hx = t_valid && m_ex_lw[d] && (m_ex_dest[d] != 0) &&
         ((t_urs && t_rs == m_ex_dest[d]) || (t_urt && t_rt == m_ex_dest[d]));
    hm = t_valid && m_mem_lw[d] && (m_mem_dest[d] != 0) &&
         ((t_urs && t_rs == m_mem_dest[d]) || (t_urt && t_rt == m_mem_dest[d]));
    return hx || (d == 1 && hm);
  endfunction

  function automatic logic [5:0] mdl_out(int d);
    if (m_err[d]) return 6'b000001;
    if (m_mem_lw[d] && !t_rdy) return 6'b000000;
    if (mdl_hz(d)) return 6'b001110;
    return 6'b111010;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    bit h, w;
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        m_ex_lw[d] = 0; m_ex_dest[d] = '0; m_mem_lw[d] = 0; m_mem_dest[d] = '0;
        m_waits[d] = 0; m_err[d] = 0; m_cnt[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        h = mdl_hz(d);
        w = m_mem_lw[d] && !t_rdy;
        if (!m_err[d]) begin
          if (w) begin
            m_waits[d]++;
            if (m_waits[d] >= MAXW) m_err[d] = 1;
            if (m_cnt[d] < (1 << CW) - 1) m_cnt[d]++;
          end else begin
            m_waits[d]   = 0;
            m_mem_lw[d]  = m_ex_lw[d];
            m_mem_dest[d] = m_ex_dest[d];
            if (h) begin
              m_ex_lw[d] = 0; m_ex_dest[d] = '0;
              if (m_cnt[d] < (1 << CW) - 1) m_cnt[d]++;
            end else begin
              m_ex_lw[d] = t_valid && t_lw; m_ex_dest[d] = t_dest;
            end
          end
        end
      end
    end
  end

  // Scoreboard: every cycle out of reset, compare both instances against the model.
  always @(negedge clock) begin
    logic [5:0] e;
    if (reset_n) begin
      for (int d = 0; d < 2; d++) begin
        e = mdl_out(d);
        checks++;
        if (obs_vec[d] !== e) begin
          errors++;
          $display("FAIL ctrl_outputs dut%0d t=%0t: got %b expected %b", d, $time, obs_vec[d], e);
        end
        checks++;
        if (obs_cnt[d] !== CW'(m_cnt[d])) begin
          errors++;
          $display("FAIL stall_count dut%0d t=%0t: got %0d expected %0d", d, $time, obs_cnt[d], m_cnt[d]);
        end
        if (obs_vec[d][2]) bub_seen[d]++;
        if (obs_vec[d] === 6'b000000) frz_seen[d]++;
      end
    end
  end

  task automatic drive(input bit v, input bit lw, input logic [RW-1:0] dest, input logic [RW-1:0] rs,
                       input logic [RW-1:0] rt, input bit urs, input bit urt, input bit rdy);
    t_valid = v; t_lw = lw; t_dest = dest; t_rs = rs; t_rt = rt;
    t_urs = urs; t_urt = urt; t_rdy = rdy;
    @(posedge clock); #1;
  endtask

  task automatic nop(input bit rdy);
    drive(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    t_valid = 0; t_lw = 0; t_dest = 0; t_rs = 0; t_rt = 0; t_urs = 0; t_urt = 0; t_rdy = 1;
    repeat (2) @(posedge clock);
    @(negedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    drive(1, 1, 8, 0, 0, 0, 0, 1);
    nop(1);
    repeat (5) nop(0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_cnt[d] !== CW'(5)) begin
        errors++; $display("FAIL pre_reset_count dut%0d: got %0d expected 5", d, obs_cnt[d]);
      end
    end
    t_rdy = 1; #1;
    reset_n = 1'b0; #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_vec[d] !== 6'b000000) begin
        errors++; $display("FAIL reset_outputs dut%0d: got %b expected 000000", d, obs_vec[d]);
      end
      checks++;
      if (obs_cnt[d] !== '0) begin
        errors++; $display("FAIL reset_count dut%0d: got %0d expected 0", d, obs_cnt[d]);
      end
    end
    @(negedge clock); #2;
    reset_n = 1'b1; #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_vec[d] !== 6'b111010 || obs_cnt[d] !== '0) begin
        errors++; $display("FAIL post_reset dut%0d: got %b/%0d expected 111010/0", d, obs_vec[d], obs_cnt[d]);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_load_use();
    int b0 [2];
    apply_reset();
    for (int d = 0; d < 2; d++) b0[d] = bub_seen[d];
    drive(1, 1, 8, 3, 0, 1, 0, 1);
    repeat (3) drive(1, 0, 10, 8, 9, 1, 1, 1);
    nop(1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (bub_seen[d] - b0[d] !== d + 1) begin
        errors++; $display("FAIL load_use_bubbles dut%0d: got %0d expected %0d", d, bub_seen[d] - b0[d], d + 1);
      end
      checks++;
      if (obs_cnt[d] !== CW'(d + 1)) begin
        errors++; $display("FAIL load_use_count dut%0d: got %0d expected %0d", d, obs_cnt[d], d + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int b0 [2];
    for (int d = 0; d < 2; d++) b0[d] = bub_seen[d];
    drive(1, 1, 8, 3, 0, 1, 0, 1);
    repeat (3) drive(1, 1, 9, 8, 0, 1, 0, 1);
    nop(1); nop(1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (bub_seen[d] - b0[d] !== d + 1) begin
        errors++; $display("FAIL lw_lw_bubbles dut%0d: got %0d expected %0d", d, bub_seen[d] - b0[d], d + 1);
      end
      checks++;
      if (obs_cnt[d] !== CW'(2 * (d + 1))) begin
        errors++; $display("FAIL lw_lw_count dut%0d: got %0d expected %0d", d, obs_cnt[d], 2 * (d + 1));
      end
    end
  endtask

  task automatic test_no_hazard();
    int b0 [2];
    apply_reset();
    for (int d = 0; d < 2; d++) b0[d] = bub_seen[d];
    drive(1, 1, 0, 3, 0, 1, 0, 1);
    drive(1, 0, 5, 0, 0, 1, 1, 1);
    drive(1, 1, 8, 3, 0, 1, 0, 1);
    drive(1, 0, 6, 3, 8, 1, 0, 1);
    drive(1, 1, 8, 3, 0, 1, 0, 1);
    drive(0, 0, 7, 8, 8, 1, 1, 1);
    drive(0, 0, 7, 8, 8, 1, 1, 1);
    nop(1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (bub_seen[d] != b0[d] || obs_cnt[d] !== '0) begin
        errors++; $display("FAIL no_hazard dut%0d: got %0d bubbles, count %0d, expected 0/0", d, bub_seen[d] - b0[d], obs_cnt[d]);
      end
    end
  endtask

  task automatic test_mem_wait();
    int f0 [2];
    apply_reset();
    for (int d = 0; d < 2; d++) f0[d] = frz_seen[d];
    drive(1, 1, 8, 3, 0, 1, 0, 1);
    nop(1);
    repeat (3) nop(0);
    nop(1); nop(1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (frz_seen[d] - f0[d] !== 3 || obs_cnt[d] !== CW'(3)) begin
        errors++; $display("FAIL mem_wait dut%0d: got %0d freezes, count %0d, expected 3/3", d, frz_seen[d] - f0[d], obs_cnt[d]);
      end
      checks++;
      if (obs_vec[d] !== 6'b111010) begin
        errors++; $display("FAIL mem_wait_release dut%0d: got %b expected 111010", d, obs_vec[d]);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    drive(1, 1, 8, 3, 0, 1, 0, 1);
    nop(1);
    repeat (MAXW - 1) nop(0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_vec[d][0] !== 1'b0) begin
        errors++; $display("FAIL timeout_early dut%0d: got %b expected 0", d, obs_vec[d][0]);
      end
    end
    nop(0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_vec[d] !== 6'b000001 || obs_cnt[d] !== CW'(MAXW)) begin
        errors++; $display("FAIL timeout_set dut%0d: got %b/%0d expected 000001/%0d", d, obs_vec[d], obs_cnt[d], MAXW);
      end
    end
    repeat (5) drive(1, 0, 4, 1, 2, 1, 1, 1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_vec[d] !== 6'b000001) begin
        errors++; $display("FAIL timeout_sticky dut%0d: got %b expected 000001", d, obs_vec[d]);
      end
    end
    apply_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_vec[d] !== 6'b111010) begin
        errors++; $display("FAIL timeout_cleared dut%0d: got %b expected 111010", d, obs_vec[d]);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    repeat (400) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0);
    end
    nop(1); nop(1);
  endtask

  initial begin
    t_valid = 0; t_lw = 0; t_dest = 0; t_rs = 0; t_rt = 0; t_urs = 0; t_urt = 0; t_rdy = 1;
    for (int d = 0; d < 2; d++) begin
      bub_seen[d] = 0; frz_seen[d] = 0;
    end
    test_reset();
    test_load_use();
    test_back_to_back();
    test_no_hazard();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
